// File: rtl/reg_alu_datapath.sv
// Execution datapath: 16x8 register file, ALU and shifter with registered
// CO/Z flags, plus result capture on the falling edge of the CU busy flag.
module reg_alu_datapath #(
  parameter int WIDTH = 8,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic [1:0]       InsSel,
  input  logic [2:0]       InMuxAdd,
  input  logic [3:0]       RegAdd,
  input  logic [3:0]       OutMuxAdd,
  input  logic [WIDTH-1:0] CUconst,
  input  logic             busy,
  input  logic [WIDTH-1:0] data_in,
  output logic             CO,
  output logic             Z,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  logic [WIDTH-1:0] rf_q [NREG];
  logic             co_q, z_q;
  logic             busy_q;
  logic [WIDTH-1:0] res_q;
  logic             rv_q;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en, flag_en, flag_co;
  logic             cap;

  assign op_a = rf_q[RegAdd];
  assign op_b = rf_q[OutMuxAdd];

  // Bit WIDTH carries the add carry-out or the subtract borrow.
  always_comb begin
    alu_wide = '0;
    unique case (InsSel)
      2'b00: alu_wide = {1'b0, op_a} + {1'b0, op_b};
      2'b01: alu_wide = {1'b0, op_a} - {1'b0, op_b};
      2'b10: alu_wide = {1'b0, op_a & op_b};
      2'b11: alu_wide = {1'b0, op_a ^ op_b};
      default: alu_wide = '0;
    endcase
  end

  always_comb begin
    wr_data = data_in;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    flag_co = 1'b0;
    unique case (InMuxAdd)
      3'b000: begin
        wr_data = data_in;
        wr_en   = WE;
      end
      3'b001: begin
        wr_data = CUconst;
        wr_en   = WE;
      end
      3'b010: begin
        wr_data = alu_wide[WIDTH-1:0];
        flag_co = alu_wide[WIDTH];
        wr_en   = WE;
        flag_en = WE;
      end
      3'b011: begin
        wr_data = op_b;
        wr_en   = WE;
      end
      3'b100: begin
        wr_data = {op_a[WIDTH-2:0], 1'b0};
        flag_co = op_a[WIDTH-1];
        wr_en   = WE;
        flag_en = WE;
      end
      3'b101: begin
        wr_data = {1'b0, op_a[WIDTH-1:1]};
        flag_co = op_a[0];
        wr_en   = WE;
        flag_en = WE;
      end
      default: begin
        wr_en   = 1'b0;
        flag_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[RegAdd] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      co_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (flag_en) begin
      co_q <= flag_co;
      z_q  <= (wr_data == '0);
    end
  end

  // Capture uses the pre-edge read, so a same-edge write is excluded.
  assign cap = busy_q & ~busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      res_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      busy_q <= busy;
      rv_q   <= cap;
      if (cap) res_q <= op_b;
    end
  end

  assign CO           = co_q;
  assign Z            = z_q;
  assign data_out     = op_b;
  assign result       = res_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_reg_alu_datapath.sv
// Bench for reg_alu_datapath: directed vector table, busy/reset corner
// sequences, then random control words against a behavioural model.
module tb_reg_alu_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       WE;
  logic [1:0] InsSel;
  logic [2:0] InMuxAdd;
  logic [3:0] RegAdd;
  logic [3:0] OutMuxAdd;
  logic [7:0] CUconst;
  logic       busy;
  logic [7:0] data_in;
  logic       CO, Z;
  logic [7:0] data_out;
  logic [7:0] result;
  logic       result_valid;

  int checks   = 0;
  int failures = 0;

  reg_alu_datapath #(.WIDTH(8), .NREG(16)) dut (
    .clk(clk), .reset(reset), .WE(WE), .InsSel(InsSel),
    .InMuxAdd(InMuxAdd), .RegAdd(RegAdd), .OutMuxAdd(OutMuxAdd),
    .CUconst(CUconst), .busy(busy), .data_in(data_in),
    .CO(CO), .Z(Z), .data_out(data_out), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       we;
    logic [1:0] ins;
    logic [2:0] mux;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] k;
    logic [7:0] din;
    logic [7:0] ev;
    logic       eco;
    logic       ez;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we,
                              input logic [1:0] ins, input logic [2:0] mux,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [7:0] k, input logic [7:0] din,
                              input logic [7:0] ev, input logic eco,
                              input logic ez);
    vec_t v;
    v.name = n; v.we = we; v.ins = ins; v.mux = mux;
    v.ra = ra; v.rb = rb; v.k = k; v.din = din;
    v.ev = ev; v.eco = eco; v.ez = ez;
    return v;
  endfunction

  // Apply one control word for one edge, then read back R[ra] and flags.
  task automatic step(input vec_t v);
    @(negedge clk);
    WE = v.we; InsSel = v.ins; InMuxAdd = v.mux;
    RegAdd = v.ra; OutMuxAdd = v.rb; CUconst = v.k; data_in = v.din;
    @(posedge clk);
    #1;
    WE = 1'b0;
    OutMuxAdd = v.ra;
    #1;
    chk({v.name, ".val"}, data_out, v.ev);
    chk({v.name, ".co"}, CO, v.eco);
    chk({v.name, ".z"}, Z, v.ez);
  endtask

  // Behavioural reference model state.
  int m_r[16];
  int m_co, m_z, m_busy, m_res, m_rv;

  task automatic model_edge(input int we, input int ins, input int mux,
                            input int ra, input int rb, input int k,
                            input int din, input int bz);
    int a, b, v, c;
    a = m_r[ra];
    b = m_r[rb];
    v = 0;
    c = 0;
    case (mux)
      0: v = din;
      1: v = k;
      2: case (ins)
           0: begin v = (a + b) % 256; c = (a + b) > 255; end
           1: begin v = (a - b + 256) % 256; c = a < b; end
           2: v = a & b;
           default: v = a ^ b;
         endcase
      3: v = b;
      4: begin v = (a * 2) % 256; c = a >= 128; end
      5: begin v = a / 2; c = a % 2; end
      default: v = 0;
    endcase
    m_rv = (m_busy == 1 && bz == 0) ? 1 : 0;
    if (m_rv == 1) m_res = b;
    m_busy = bz;
    if (we == 1 && mux < 6) m_r[ra] = v;
    if (we == 1 && (mux == 2 || mux == 4 || mux == 5)) begin
      m_co = c;
      m_z  = (v == 0) ? 1 : 0;
    end
  endtask

  initial begin
    vt.push_back(mk("k_r3",       1, 0, 1, 3, 3, 8'h2A, 8'h00, 8'h2A, 0, 0));
    vt.push_back(mk("din_r1",     1, 0, 0, 1, 1, 8'h00, 8'hF0, 8'hF0, 0, 0));
    vt.push_back(mk("k_r2",       1, 0, 1, 2, 2, 8'h20, 8'h00, 8'h20, 0, 0));
    vt.push_back(mk("add_co",     1, 0, 2, 1, 2, 8'h00, 8'h00, 8'h10, 1, 0));
    vt.push_back(mk("k_r1_55",    1, 0, 1, 1, 1, 8'h55, 8'h00, 8'h55, 1, 0));
    vt.push_back(mk("k_r2_55",    1, 0, 1, 2, 2, 8'h55, 8'h00, 8'h55, 1, 0));
    vt.push_back(mk("sub_eq",     1, 1, 2, 1, 2, 8'h00, 8'h00, 8'h00, 0, 1));
    vt.push_back(mk("k_r1_10",    1, 0, 1, 1, 1, 8'h10, 8'h00, 8'h10, 0, 1));
    vt.push_back(mk("k_r2_20",    1, 0, 1, 2, 2, 8'h20, 8'h00, 8'h20, 0, 1));
    vt.push_back(mk("sub_borrow", 1, 1, 2, 1, 2, 8'h00, 8'h00, 8'hF0, 1, 0));
    vt.push_back(mk("k_r4_81",    1, 0, 1, 4, 4, 8'h81, 8'h00, 8'h81, 1, 0));
    vt.push_back(mk("shl",        1, 0, 4, 4, 4, 8'h00, 8'h00, 8'h02, 1, 0));
    vt.push_back(mk("shr",        1, 0, 5, 4, 4, 8'h00, 8'h00, 8'h01, 0, 0));
    vt.push_back(mk("shr_zero",   1, 0, 5, 4, 4, 8'h00, 8'h00, 8'h00, 1, 1));
    vt.push_back(mk("we0_xor",    0, 3, 2, 1, 3, 8'h00, 8'h00, 8'hF0, 1, 1));
    vt.push_back(mk("rsv110",     1, 3, 6, 1, 3, 8'h00, 8'h00, 8'hF0, 1, 1));
    vt.push_back(mk("rsv111",     1, 0, 7, 1, 3, 8'h00, 8'h00, 8'hF0, 1, 1));
    vt.push_back(mk("xor",        1, 3, 2, 1, 3, 8'h00, 8'h00, 8'hDA, 0, 0));
    vt.push_back(mk("we0_add",    0, 0, 2, 1, 1, 8'h00, 8'h00, 8'hDA, 0, 0));
    vt.push_back(mk("and",        1, 2, 2, 1, 3, 8'h00, 8'h00, 8'h0A, 0, 0));
    vt.push_back(mk("mov_zero",   1, 0, 3, 5, 4, 8'h00, 8'h00, 8'h00, 0, 0));
    vt.push_back(mk("k_r0",       1, 0, 1, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 0));
    vt.push_back(mk("mov_r0",     1, 0, 3, 7, 0, 8'h00, 8'h00, 8'hFF, 0, 0));
    vt.push_back(mk("add_carry",  1, 0, 2, 0, 0, 8'h00, 8'h00, 8'hFE, 1, 0));
    vt.push_back(mk("k_r2_37",    1, 0, 1, 2, 2, 8'h37, 8'h00, 8'h37, 1, 0));

    reset = 1'b0; WE = 1'b0; InsSel = '0; InMuxAdd = '0; RegAdd = '0;
    OutMuxAdd = '0; CUconst = '0; busy = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.co", CO, 0);
    chk("rst.z", Z, 0);
    chk("rst.result", result, 0);
    chk("rst.rv", result_valid, 0);
    for (int i = 0; i < 16; i++) begin
      OutMuxAdd = 4'(i);
      #0.1;
      chk($sformatf("rst.r%0d", i), data_out, 0);
    end

    foreach (vt[i]) step(vt[i]);

    // One-cycle busy pulse captures once; rising edge captures nothing.
    @(negedge clk);
    WE = 1'b0; busy = 1'b1; OutMuxAdd = 4'd3;
    @(posedge clk); #1;
    chk("rise.rv", result_valid, 0);
    chk("rise.result", result, 0);
    @(negedge clk);
    busy = 1'b0;
    @(posedge clk); #1;
    chk("pulse.result", result, 8'h2A);
    chk("pulse.rv", result_valid, 1);
    @(posedge clk); #1;
    chk("pulse.rv_drop", result_valid, 0);
    chk("pulse.hold", result, 8'h2A);

    // Capture with a same-edge write to the captured register.
    @(negedge clk);
    busy = 1'b1; OutMuxAdd = 4'd2;
    @(negedge clk);
    busy = 1'b0; WE = 1'b1; InMuxAdd = 3'b001; RegAdd = 4'd2;
    CUconst = 8'h99;
    @(posedge clk); #1;
    WE = 1'b0;
    #0.5;
    chk("cap.result", result, 8'h37);
    chk("cap.rv", result_valid, 1);
    chk("cap.newval", data_out, 8'h99);

    // Asynchronous reset between edges clears everything at once.
    busy = 1'b1;
    #1.5;
    reset = 1'b0;
    #1;
    chk("arst.rv", result_valid, 0);
    chk("arst.result", result, 0);
    chk("arst.co", CO, 0);
    chk("arst.z", Z, 0);
    chk("arst.r2", data_out, 0);
    for (int i = 0; i < 16; i++) begin
      OutMuxAdd = 4'(i);
      #0.1;
      chk($sformatf("arst.r%0d", i), data_out, 0);
    end

    @(negedge clk);
    busy = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_co = 0; m_z = 0; m_busy = 0; m_res = 0; m_rv = 0;

    for (int n = 0; n < 400; n++) begin
      int we, ins, mux, ra, rb, k, din, bz;
      @(negedge clk);
      we  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ins = $urandom_range(0, 3);
      mux = $urandom_range(0, 7);
      ra  = $urandom_range(0, 15);
      rb  = $urandom_range(0, 15);
      k   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      din = $urandom_range(0, 255);
      bz  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      WE = we[0]; InsSel = 2'(ins); InMuxAdd = 3'(mux);
      RegAdd = 4'(ra); OutMuxAdd = 4'(rb);
      CUconst = 8'(k); data_in = 8'(din); busy = bz[0];
      #1;
      chk("rnd.data_out", data_out, m_r[rb]);
      model_edge(we, ins, mux, ra, rb, k, din, bz);
      @(posedge clk); #1;
      chk("rnd.co", CO, m_co);
      chk("rnd.z", Z, m_z);
      chk("rnd.result", result, m_res);
      chk("rnd.rv", result_valid, m_rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
